// File: rtl/seq_nibble_mult.sv
// Sequential multiplier: one 4x4 digit partial product per cycle into a 2*WIDTH
// accumulator, with sign-magnitude handling for two's-complement operands.
module seq_nibble_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset_a,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   data_a,
  input  logic [WIDTH-1:0]   data_b,
  output logic               busy,
  output logic               done_flag,
  output logic [2*WIDTH-1:0] product_out,
  output logic [1:0]         state_out
);

  localparam int K    = WIDTH / 4;
  localparam int NPP  = K * K;
  localparam int PW   = 2 * WIDTH;
  localparam int CW   = (K > 1) ? $clog2(K) : 1;
  localparam int NW   = (NPP > 1) ? $clog2(NPP) : 1;
  localparam logic [CW-1:0] LAST_DIGIT = CW'(K - 1);
  localparam logic [NW-1:0] LAST_PP    = NW'(NPP - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t          state_r;
  state_t          next_state_s;
  logic [WIDTH-1:0] mag_a_r;
  logic [WIDTH-1:0] mag_b_r;
  logic            neg_r;
  logic [PW-1:0]   acc_r;
  logic [CW-1:0]   i_r;
  logic [CW-1:0]   j_r;
  logic [NW-1:0]   pp_cnt_r;
  logic            busy_r;
  logic            done_r;
  logic [PW-1:0]   product_r;

  logic            last_pp_s;
  logic [3:0]      a_dig_s;
  logic [3:0]      b_dig_s;
  logic [7:0]      pp_s;
  logic [CW:0]     pos_s;
  logic [PW-1:0]   pp_shift_s;

  // Magnitude of a possibly negative operand; the most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic neg);
    if (neg) begin
      magnitude = ~v + WIDTH'(1);
    end else begin
      magnitude = v;
    end
  endfunction

  // Two's-complement negation of the accumulated magnitude.
  function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic neg);
    if (neg) begin
      apply_sign = ~v + PW'(1);
    end else begin
      apply_sign = v;
    end
  endfunction

  assign last_pp_s  = (pp_cnt_r == LAST_PP);
  assign a_dig_s    = mag_a_r[{i_r, 2'b00} +: 4];
  assign b_dig_s    = mag_b_r[{j_r, 2'b00} +: 4];
  assign pp_s       = a_dig_s * b_dig_s;
  assign pos_s      = {1'b0, i_r} + {1'b0, j_r};
  assign pp_shift_s = PW'(pp_s) << {pos_s, 2'b00};

  // State register.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          next_state_s = CALC;
        end else begin
          next_state_s = IDLE;
        end
      end
      CALC: begin
        if (last_pp_s) begin
          next_state_s = FIX;
        end else begin
          next_state_s = CALC;
        end
      end
      FIX:     next_state_s = DONE;
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Operand latch, digit walk, accumulation and final sign fix-up.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      mag_a_r   <= '0;
      mag_b_r   <= '0;
      neg_r     <= 1'b0;
      acc_r     <= '0;
      i_r       <= '0;
      j_r       <= '0;
      pp_cnt_r  <= '0;
      product_r <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mag_a_r  <= magnitude(data_a, signed_mode & data_a[WIDTH-1]);
            mag_b_r  <= magnitude(data_b, signed_mode & data_b[WIDTH-1]);
            neg_r    <= signed_mode & (data_a[WIDTH-1] ^ data_b[WIDTH-1]);
            acc_r    <= '0;
            i_r      <= '0;
            j_r      <= '0;
            pp_cnt_r <= '0;
          end
        end
        CALC: begin
          acc_r    <= acc_r + pp_shift_s;
          pp_cnt_r <= pp_cnt_r + NW'(1);
          // j is the inner digit index; i advances when j wraps.
          if (j_r == LAST_DIGIT) begin
            j_r <= '0;
            i_r <= i_r + CW'(1);
          end else begin
            j_r <= j_r + CW'(1);
          end
        end
        FIX: begin
          product_r <= apply_sign(acc_r, neg_r);
        end
        default: begin
        end
      endcase
    end
  end

  // Status outputs registered from the next state so they line up with state_out.
  always_ff @(posedge clk or negedge reset_a) begin
    if (!reset_a) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (next_state_s != IDLE);
      done_r <= (next_state_s == DONE);
    end
  end

  assign busy        = busy_r;
  assign done_flag   = done_r;
  assign product_out = product_r;
  assign state_out   = state_r;

endmodule

// File: tb/tb_seq_nibble_mult.sv
// Directed bench for seq_nibble_mult at WIDTH=8 and WIDTH=16 with hand-computed products
// and cycle-exact busy/done/state checks relative to the start acceptance edge.
module tb_seq_nibble_mult;

  logic        clk;
  logic        reset_a;
  logic        start8, sm8;
  logic [7:0]  a8, b8;
  logic        busy8, done8;
  logic [15:0] prod8;
  logic [1:0]  st8;
  logic        start16, sm16;
  logic [15:0] a16, b16;
  logic        busy16, done16;
  logic [31:0] prod16;
  logic [1:0]  st16;

  int checks_r;
  int failures_r;

  seq_nibble_mult #(.WIDTH(8)) dut8 (
    .clk(clk), .reset_a(reset_a), .start(start8), .signed_mode(sm8),
    .data_a(a8), .data_b(b8), .busy(busy8), .done_flag(done8),
    .product_out(prod8), .state_out(st8)
  );

  seq_nibble_mult #(.WIDTH(16)) dut16 (
    .clk(clk), .reset_a(reset_a), .start(start16), .signed_mode(sm16),
    .data_a(a16), .data_b(b16), .busy(busy16), .done_flag(done16),
    .product_out(prod16), .state_out(st16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks_r++;
    if (obs !== exp_v) begin
      failures_r++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // One WIDTH=8 operation; k counts cycles after the acceptance edge (cycle T+k).
  task automatic run8(input string tag, input logic sm, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] exp_v, input bit inject);
    logic [15:0] prev;
    @(negedge clk);
    prev   = prod8;
    start8 = 1'b1; sm8 = sm; a8 = a; b8 = b;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~a; b8 = ~b; sm8 = ~sm;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      check($sformatf("%s_busy_T%0d", tag, k), {31'd0, busy8}, {31'd0, (k <= 6)});
      check($sformatf("%s_done_T%0d", tag, k), {31'd0, done8}, {31'd0, (k == 6)});
      check($sformatf("%s_state_T%0d", tag, k), {30'd0, st8},
            (k <= 4) ? 32'd1 : (k == 5) ? 32'd2 : (k == 6) ? 32'd3 : 32'd0);
      if (k <= 4) check($sformatf("%s_hold_T%0d", tag, k), {16'd0, prod8}, {16'd0, prev});
      if (k >= 6) check($sformatf("%s_prod_T%0d", tag, k), {16'd0, prod8}, {16'd0, exp_v});
      if (inject && k == 3) begin
        start8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
        @(posedge clk); #1;
        start8 = 1'b0;
      end
    end
  endtask

  task automatic run16(input string tag, input logic sm, input logic [15:0] a, input logic [15:0] b,
                       input logic [31:0] exp_v);
    @(negedge clk);
    start16 = 1'b1; sm16 = sm; a16 = a; b16 = b;
    @(posedge clk); #1;
    start16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
    for (int k = 1; k <= 19; k++) begin
      @(negedge clk);
      check($sformatf("%s_done_T%0d", tag, k), {31'd0, done16}, {31'd0, (k == 18)});
      check($sformatf("%s_busy_T%0d", tag, k), {31'd0, busy16}, {31'd0, (k <= 18)});
      if (k == 18) check($sformatf("%s_prod", tag), prod16, exp_v);
    end
  endtask

  initial begin
    checks_r = 0; failures_r = 0;
    reset_a = 1'b0;
    start8 = 1'b0; sm8 = 1'b0; a8 = 8'h00; b8 = 8'h00;
    start16 = 1'b0; sm16 = 1'b0; a16 = 16'h0000; b16 = 16'h0000;
    #3;
    check("rst_prod", {16'd0, prod8}, 32'd0);
    check("rst_state", {30'd0, st8}, 32'd0);
    check("rst_busy", {31'd0, busy8}, 32'd0);
    check("rst_done", {31'd0, done8}, 32'd0);
    check("rst_prod16", prod16, 32'd0);
    @(negedge clk);
    reset_a = 1'b1;

    run8("u_ff_ff",   1'b0, 8'hFF, 8'hFF, 16'hFE01, 1'b0);
    run8("s_m128sq",  1'b1, 8'h80, 8'h80, 16'h4000, 1'b0);
    run8("s_m3x5",    1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0);
    run8("s_0xm7",    1'b1, 8'h00, 8'hF9, 16'h0000, 1'b0);
    run8("u_fdx5",    1'b0, 8'hFD, 8'h05, 16'h04F1, 1'b0);
    run8("s_127xm128",1'b1, 8'h7F, 8'h80, 16'hC080, 1'b0);
    run8("u_inject",  1'b0, 8'h12, 8'h34, 16'h03A8, 1'b1);

    // Reset in the middle of an operation discards it completely.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    reset_a = 1'b0;
    #1;
    check("mid_rst_prod", {16'd0, prod8}, 32'd0);
    check("mid_rst_state", {30'd0, st8}, 32'd0);
    check("mid_rst_busy", {31'd0, busy8}, 32'd0);
    check("mid_rst_done", {31'd0, done8}, 32'd0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check($sformatf("rst_hold_done%0d", k), {31'd0, done8}, 32'd0);
      check($sformatf("rst_hold_state%0d", k), {30'd0, st8}, 32'd0);
    end
    reset_a = 1'b1;
    run8("after_rst", 1'b1, 8'hFD, 8'h05, 16'hFFF1, 1'b0);

    // Start held high: second operation accepted in the IDLE cycle after DONE.
    @(negedge clk);
    start8 = 1'b1; sm8 = 1'b0; a8 = 8'h12; b8 = 8'h34;
    @(posedge clk); #1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check($sformatf("b2b_done_T%0d", k), {31'd0, done8}, {31'd0, (k == 6 || k == 13)});
      if (k == 6) check("b2b_prod1", {16'd0, prod8}, 32'h03A8);
      if (k == 7) begin
        check("b2b_idle", {30'd0, st8}, 32'd0);
        check("b2b_prod1_hold", {16'd0, prod8}, 32'h03A8);
      end
      if (k == 8) check("b2b_calc", {30'd0, st8}, 32'd1);
      if (k == 13) begin
        check("b2b_prod2", {16'd0, prod8}, 32'h01FE);
        start8 = 1'b0;
      end
      if (k == 3) begin
        a8 = 8'hFF; b8 = 8'h02;
      end
    end

    run16("w16_ffff", 1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001);
    run16("w16_sneg", 1'b1, 16'h8000, 16'h0002, 32'hFFFF0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
    $finish;
  end

endmodule

// File: doc/seq_nibble_mult.md
SEQ_NIBBLE_MULT -- requirements
Module: seq_nibble_mult

Interface
- Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 8, operand width in bits; legal values are multiples of 4 from 4 to 32.
REQ-002 The block SHALL derive K = WIDTH/4 (digits per operand) and NPP = K*K (partial products per operation).
- Ports:
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_a  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have port start  input  1  operation request, sampled only in IDLE.
REQ-006 The block SHALL have port signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start.
REQ-007 The block SHALL have port data_a  input  WIDTH  multiplicand, sampled with start.
REQ-008 The block SHALL have port data_b  input  WIDTH  multiplier, sampled with start.
REQ-009 The block SHALL have port busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-010 The block SHALL have port done_flag  output  1  single-cycle pulse marking a new valid product.
REQ-011 The block SHALL have port product_out  output  2*WIDTH  registered result.
REQ-012 The block SHALL have port state_out  output  2  current state: IDLE=0, CALC=1, FIX=2, DONE=3.

Function
REQ-013 The block SHALL implement the four states IDLE, CALC, FIX and DONE.
REQ-014 In IDLE with start=1 (cycle T), the block SHALL latch data_a, data_b and signed_mode, clear the internal accumulator and partial-product index, and enter CALC.
REQ-015 In signed mode, the block SHALL latch operand magnitudes as unsigned WIDTH-bit values (|-2^(WIDTH-1)| = 2^(WIDTH-1), no overflow) and record the result sign as sign(a) XOR sign(b).
REQ-016 In CALC, the block SHALL add one 4x4 unsigned partial product per cycle, a_digit[i]*b_digit[j] shifted left by 4*(i+j), into a 2*WIDTH accumulator, ordering i outer and j inner, each from 0 to K-1.
REQ-017 The block SHALL leave CALC for FIX after exactly NPP CALC cycles (cycles T+1 .. T+NPP).
REQ-018 In FIX (cycle T+NPP+1), the block SHALL write product_out with the accumulator, two's-complement negated when the recorded sign is 1 and signed mode was latched.
REQ-019 In DONE (cycle T+NPP+2), the block SHALL assert done_flag=1 for exactly one cycle and return to IDLE on the next edge.
REQ-020 For WIDTH=8, done_flag SHALL be high in cycle T+6, and the next start SHALL be accepted no earlier than T+7.
REQ-021 product_out SHALL hold its previous value throughout CALC and change only in FIX, remaining stable until the next FIX or reset.
REQ-022 start SHALL be ignored in CALC, FIX and DONE; no queuing, and latched operands SHALL be unaffected by input changes.
REQ-023 With start held high continuously, the block SHALL begin back-to-back operations, each accepted in the IDLE cycle following DONE.
REQ-024 Arithmetic SHALL be exact modulo 2^(2*WIDTH); no result overflows 2*WIDTH bits in either mode.
REQ-025 An operand of zero SHALL still take the full NPP cycles and produce product_out=0 (never negative zero).

Reset
REQ-026 reset_a=0 SHALL force, asynchronously and in any state, state=IDLE, busy=0, done_flag=0, product_out=0, state_out=0, and clear the accumulator, index and latched operands.
REQ-027 An operation interrupted by reset SHALL be discarded entirely: no done_flag and no partial result on product_out.
REQ-028 After reset_a rises, the first start SHALL be accepted on the first rising clk edge at which it is sampled high.

Verification
REQ-029 WIDTH=8, unsigned, 255*255 -> product_out=0xFE01 and done_flag high at T+6 only; busy high T+1..T+6.
REQ-030 WIDTH=8, signed, -128*-128 -> 0x4000; -3*5 -> 0xFFF1; 0*-7 -> 0x0000.
REQ-031 WIDTH=8, unsigned, 0xFD*0x05 -> 0x04F1; the same operands in signed mode -> -15 = 0xFFF1.
REQ-032 WIDTH=8, start pulsed at T+3 with different operands -> ignored; result is that of the first operation, and busy falls after T+6.
REQ-033 WIDTH=8, reset_a low at T+3 -> outputs cleared immediately (before the next edge), no done_flag; a restart then completes normally.
REQ-034 WIDTH=16, unsigned, 0xFFFF*0xFFFF -> 0xFFFE0001 with done_flag at T+18.
